// File: rtl/dca_matrix_lsu_txn_sched_pkg.sv
// dca_matrix_lsu_txn_sched_pkg: FSM states, descriptor widths and sizing helpers for the matrix store sequencer
package dca_matrix_lsu_txn_sched_pkg;
  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} sched_state_e;
  localparam int ALEN_W = 8;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int mat_dim(input int size_para);
    return 1 << size_para;
  endfunction
endpackage

// File: rtl/dca_txn_outstanding_cnt.sv
// dca_txn_outstanding_cnt: saturating count of issued-but-unacknowledged bursts with limit/zero flags
module dca_txn_outstanding_cnt
  import dca_matrix_lsu_txn_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic at_limit,
  output logic zero
);
  localparam int CW = clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic up, dn;
  assign at_limit = cnt_q >= CW'(MAX_OUTSTANDING);
  assign zero = cnt_q == '0;
  assign up = inc && !at_limit;
  assign dn = dec && !zero;
  always_comb cnt_d = up == dn ? cnt_q : up ? cnt_q + 1'b1 : cnt_q - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dca_matrix_lsu_txn_sched.sv
// dca_matrix_lsu_txn_sched: walks a matrix store row by row and emits per-burst write descriptors
module dca_matrix_lsu_txn_sched
  import dca_matrix_lsu_txn_sched_pkg::*;
#(
  parameter int BW_AXI_ADDR      = 32,
  parameter int BW_AXI_DATA      = 32,
  parameter int BW_ELEMENT       = 32,
  parameter int MATRIX_SIZE_PARA = 4,
  parameter int MAX_BURST_LEN    = 16,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  input  logic [BW_AXI_ADDR-1:0]      inst_addr,
  input  logic [BW_AXI_ADDR-1:0]      inst_stride,
  input  logic [MATRIX_SIZE_PARA-1:0] inst_num_row_m1,
  input  logic [MATRIX_SIZE_PARA-1:0] inst_num_col_m1,
  output logic                        txn_valid,
  input  logic                        txn_ready,
  output logic [BW_AXI_ADDR+2:0]      txn_bitaddr,
  output logic [ALEN_W-1:0]           txn_alen,
  output logic                        txn_last,
  output logic                        txn_skip,
  input  logic                        wdone,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  localparam int M = MATRIX_SIZE_PARA;
  localparam int BPB_SH = clog2(BW_AXI_DATA / 8);
  localparam int EPB = BW_AXI_DATA / BW_ELEMENT;
  localparam int EPB_SH = clog2(EPB);
  localparam int MAX_ROW_BEATS = ceil_div(mat_dim(M) * BW_ELEMENT, BW_AXI_DATA);
  localparam int BT_W = clog2((MAX_ROW_BEATS > MAX_BURST_LEN ? MAX_ROW_BEATS : MAX_BURST_LEN) + 1);
  localparam logic [BW_AXI_ADDR-1:0] ALIGN_MASK = BW_AXI_ADDR'((BW_AXI_DATA / 8) - 1);
  typedef logic [BW_AXI_ADDR-1:0] addr_t;
  typedef logic [BT_W-1:0] beats_t;
  sched_state_e state_q, state_d;
  addr_t addr_q, addr_d, stride_q, stride_d, row_ptr_q, row_ptr_d, burst_ptr_q, burst_ptr_d;
  logic [M-1:0] nrow_q, nrow_d, ncol_q, ncol_d, row_cnt_q, row_cnt_d;
  beats_t row_beats_q, row_beats_d, beats_left_q, beats_left_d, beats, rb;
  logic skip_q, skip_d, err_q, err_d, done_q, done_d;
  logic at_limit, cnt_zero, hs, in_issue, last_burst, mis;
  // element count per row rounded up to whole bus beats; widths are powers of two
  assign rb = beats_t'((int'(ncol_q) + EPB) >> EPB_SH);
  assign mis = ((addr_q | stride_q) & ALIGN_MASK) != '0;
  assign beats = beats_left_q > beats_t'(MAX_BURST_LEN) ? beats_t'(MAX_BURST_LEN) : beats_left_q;
  assign last_burst = row_cnt_q == nrow_q && beats_left_q == beats;
  assign in_issue = state_q == ISSUE;
  assign hs = txn_valid && txn_ready;
  assign inst_ready = state_q == IDLE;
  assign busy = !inst_ready;
  assign done = done_q;
  assign err = err_q;
  assign txn_valid = in_issue && !at_limit;
  assign txn_bitaddr = in_issue ? {burst_ptr_q, 3'b000} : '0;
  assign txn_alen = in_issue && !skip_q ? ALEN_W'(beats - 1'b1) : '0;
  assign txn_last = in_issue && (skip_q || last_burst);
  assign txn_skip = in_issue && skip_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    stride_d = stride_q;
    nrow_d = nrow_q;
    ncol_d = ncol_q;
    row_ptr_d = row_ptr_q;
    burst_ptr_d = burst_ptr_q;
    row_cnt_d = row_cnt_q;
    row_beats_d = row_beats_q;
    beats_left_d = beats_left_q;
    skip_d = skip_q;
    err_d = err_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (inst_valid) begin
        state_d = CALC;
        addr_d = inst_addr;
        stride_d = inst_stride;
        nrow_d = inst_num_row_m1;
        ncol_d = inst_num_col_m1;
        err_d = 1'b0;
      end
      CALC: begin
        state_d = ISSUE;
        row_beats_d = rb;
        beats_left_d = rb;
        row_ptr_d = addr_q;
        burst_ptr_d = addr_q;
        row_cnt_d = '0;
        skip_d = mis;
        err_d = mis;
      end
      ISSUE: if (hs) begin
        if (skip_q || last_burst) state_d = DRAIN;
        else if (beats_left_q == beats) begin
          row_cnt_d = row_cnt_q + 1'b1;
          row_ptr_d = row_ptr_q + stride_q;
          burst_ptr_d = row_ptr_q + stride_q;
          beats_left_d = row_beats_q;
        end else begin
          burst_ptr_d = burst_ptr_q + (addr_t'(beats) << BPB_SH);
          beats_left_d = beats_left_q - beats;
        end
      end
      DRAIN: if (cnt_zero) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      stride_q <= '0;
      nrow_q <= '0;
      ncol_q <= '0;
      row_ptr_q <= '0;
      burst_ptr_q <= '0;
      row_cnt_q <= '0;
      row_beats_q <= '0;
      beats_left_q <= '0;
      skip_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      stride_q <= stride_d;
      nrow_q <= nrow_d;
      ncol_q <= ncol_d;
      row_ptr_q <= row_ptr_d;
      burst_ptr_q <= burst_ptr_d;
      row_cnt_q <= row_cnt_d;
      row_beats_q <= row_beats_d;
      beats_left_q <= beats_left_d;
      skip_q <= skip_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  // skip descriptors carry no data, so they never wait for a completion
  dca_txn_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hs && !skip_q),
    .dec(wdone),
    .at_limit(at_limit),
    .zero(cnt_zero)
  );
endmodule
